ps2_host_tx: RTL and testbench

//  Host-to-device transmitter for the PS/2 keyboard port: sends one command byte (LED set
//  0xED, reset 0xFF, typematic 0xF3, ...) to the keyboard, the opposite direction of the

---
 rtl/ps2_host_tx.sv | 189 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte to the keyboard using
// open-drain pull-low enables on the PS/2 clock and data lines.
module ps2_host_tx #(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int unsigned INHIBIT_US  = 100,
    parameter int unsigned START_TO_US = 15000,
    parameter int unsigned FRAME_TO_US = 2000,
    parameter int unsigned FILT        = 8
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic [7:0] tx_dat,
    input  logic       tx_stb,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int unsigned CYC_PER_US = CLK_HZ / 1_000_000;
    localparam int unsigned INHIB_CYC  = INHIBIT_US * CYC_PER_US;
    localparam int unsigned START_CYC  = START_TO_US * CYC_PER_US;
    localparam int unsigned FRAME_CYC  = FRAME_TO_US * CYC_PER_US;
    localparam int unsigned MAX_AB     = (INHIB_CYC > START_CYC) ? INHIB_CYC : START_CYC;
    localparam int unsigned TMR_MAX    = (MAX_AB > FRAME_CYC) ? MAX_AB : FRAME_CYC;
    localparam int unsigned TMR_W      = $clog2(TMR_MAX + 1);
    localparam int unsigned FCNT_W     = $clog2(FILT + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_INHIB, S_START, S_REQ, S_BITS, S_ACK, S_WREL, S_DONE, S_ERR
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [TMR_W-1:0]    r_tmr, w_tmr_nxt;
    logic [3:0]          r_n, w_n_nxt;
    logic [8:0]          r_frame, w_frame_nxt;
    logic                r_clk_s1, r_clk_s2, r_data_s1, r_data_s2;
    logic                r_clk_f, w_clk_f_nxt;
    logic [FCNT_W-1:0]   r_fcnt, w_fcnt_nxt;
    logic                r_fall, w_fall_nxt;
    logic                r_tx_busy, r_tx_done, r_tx_err, r_clk_oe, r_data_oe;
    logic                w_tmo;

    assign tx_busy     = r_tx_busy;
    assign tx_done     = r_tx_done;
    assign tx_err      = r_tx_err;
    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;

    // Glitch filter: the filtered clock follows the synced pin only after FILT equal samples.
    always_comb begin
        w_clk_f_nxt = r_clk_f;
        w_fcnt_nxt  = '0;
        w_fall_nxt  = 1'b0;
        if (r_clk_s2 != r_clk_f) begin
            if (r_fcnt == FCNT_W'(FILT - 1)) begin
                w_clk_f_nxt = r_clk_s2;
                w_fall_nxt  = ~r_clk_s2;
            end else begin
                w_fcnt_nxt = r_fcnt + FCNT_W'(1);
            end
        end
    end

    // Frame timeout shared by BITS, ACK and WREL.
    assign w_tmo = (r_tmr >= TMR_W'(FRAME_CYC - 1));

    // Next-state and datapath logic; bits shift out LSB first on each filtered falling edge.
    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        w_n_nxt     = r_n;
        w_frame_nxt = r_frame;
        case (r_state)
            S_IDLE: begin
                w_tmr_nxt = '0;
                w_n_nxt   = '0;
                if (tx_stb) begin
                    w_frame_nxt = {~^tx_dat, tx_dat};
                    w_state_nxt = S_INHIB;
                end
            end
            S_INHIB: begin
                if (r_tmr == TMR_W'(INHIB_CYC - 1)) begin
                    w_tmr_nxt   = '0;
                    w_state_nxt = S_START;
                end else begin
                    w_tmr_nxt = r_tmr + TMR_W'(1);
                end
            end
            S_START: begin
                w_tmr_nxt   = '0;
                w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (r_fall) begin
                    w_tmr_nxt   = '0;
                    w_n_nxt     = 4'd1;
                    w_state_nxt = S_BITS;
                end else if (r_tmr >= TMR_W'(START_CYC - 1)) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_tmr_nxt = r_tmr + TMR_W'(1);
                end
            end
            S_BITS: begin
                if (w_tmo) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_tmr_nxt = r_tmr + TMR_W'(1);
                    if (r_fall) begin
                        w_frame_nxt = {1'b1, r_frame[8:1]};
                        w_n_nxt     = r_n + 4'd1;
                        if (r_n == 4'd9) begin
                            w_state_nxt = S_ACK;
                        end
                    end
                end
            end
            S_ACK: begin
                if (w_tmo) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_tmr_nxt = r_tmr + TMR_W'(1);
                    if (r_fall) begin
                        w_state_nxt = r_data_s2 ? S_ERR : S_WREL;
                    end
                end
            end
            S_WREL: begin
                if (w_tmo) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_tmr_nxt = r_tmr + TMR_W'(1);
                    if (r_clk_f && r_data_s2) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_ERR:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Registers: synchronizers, filter, FSM state and outputs decoded from the next state.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_clk_s1  <= 1'b1;
            r_clk_s2  <= 1'b1;
            r_data_s1 <= 1'b1;
            r_data_s2 <= 1'b1;
            r_clk_f   <= 1'b1;
            r_fcnt    <= '0;
            r_fall    <= 1'b0;
            r_state   <= S_IDLE;
            r_tmr     <= '0;
            r_n       <= '0;
            r_frame   <= '0;
            r_tx_busy <= 1'b0;
            r_tx_done <= 1'b0;
            r_tx_err  <= 1'b0;
            r_clk_oe  <= 1'b0;
            r_data_oe <= 1'b0;
        end else begin
            r_clk_s1  <= ps2_clk_i;
            r_clk_s2  <= r_clk_s1;
            r_data_s1 <= ps2_data_i;
            r_data_s2 <= r_data_s1;
            r_clk_f   <= w_clk_f_nxt;
            r_fcnt    <= w_fcnt_nxt;
            r_fall    <= w_fall_nxt;
            r_state   <= w_state_nxt;
            r_tmr     <= w_tmr_nxt;
            r_n       <= w_n_nxt;
            r_frame   <= w_frame_nxt;
            r_tx_busy <= (w_state_nxt != S_IDLE);
            r_tx_done <= (w_state_nxt == S_DONE);
            r_tx_err  <= (w_state_nxt == S_ERR);
            r_clk_oe  <= (w_state_nxt == S_INHIB) || (w_state_nxt == S_START);
            r_data_oe <= (w_state_nxt == S_START) || (w_state_nxt == S_REQ) ||
                         ((w_state_nxt == S_BITS) && !w_frame_nxt[0]);
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple open-drain PS/2 device model.
module tb_ps2_host_tx;

    localparam int unsigned CLK_HZ      = 1_000_000;
    localparam int unsigned INHIBIT_US  = 100;
    localparam int unsigned START_TO_US = 15000;
    localparam int unsigned FRAME_TO_US = 2000;
    localparam int unsigned FILT        = 8;
    // One clock per microsecond, so the timeouts in cycles equal the microsecond values.
    localparam int INHIB_CYC = 100;
    localparam int START_CYC = 15000;
    localparam int FRAME_CYC = 2000;
    localparam int HALF      = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_dat = 8'h00;
    logic       tx_stb = 1'b0;
    logic       tx_busy, tx_done, tx_err;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_i, ps2_data_i;

    int n_chk  = 0;
    int n_fail = 0;
    int n_done = 0;
    int n_err  = 0;
    int cyc    = 0;
    int t_fall1 = 0;

    assign ps2_clk_i  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_i = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .CLK_HZ(CLK_HZ), .INHIBIT_US(INHIBIT_US), .START_TO_US(START_TO_US),
        .FRAME_TO_US(FRAME_TO_US), .FILT(FILT)
    ) u_dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .tx_dat(tx_dat), .tx_stb(tx_stb),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_err(tx_err),
        .ps2_clk_i(ps2_clk_i), .ps2_data_i(ps2_data_i),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;

    // Cycle counter and pulse counters sampled on the rising edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_done) n_done <= n_done + 1;
        if (tx_err)  n_err  <= n_err + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] d);
        tx_dat = d;
        tx_stb = 1'b1;
        tick(1);
        tx_stb = 1'b0;
    endtask

    // Device side: wait for the host request, clock nclk falling edges, sample each bit
    // on the rising edge, optionally ACK on the 11th edge and inject a short clock glitch.
    task automatic dev_frame(input int nclk, input logic ack_low, input int glitch_k,
                             output logic [9:0] bits);
        bit seen = 1'b0;
        bits = '1;
        for (int i = 0; i < INHIB_CYC + 50; i++) begin
            if (!ps2_clk_oe && ps2_data_oe) begin
                seen = 1'b1;
                break;
            end
            tick(1);
        end
        chk("req_seen", 32'(seen), 32'd1);
        if (!seen) return;
        chk("start_bit", 32'(ps2_data_i), 32'd0);
        tick(30);
        for (int k = 1; k <= nclk; k++) begin
            if (k == 11) begin
                dev_data = ~ack_low;
                tick(5);
            end
            dev_clk = 1'b0;
            if (k == 1) t_fall1 = cyc;
            tick(HALF);
            dev_clk = 1'b1;
            if (k <= 10) bits[k-1] = ps2_data_i;
            if (k == glitch_k) begin
                tick(HALF / 2);
                dev_clk = 1'b0;
                tick(int'(FILT) / 2);
                dev_clk = 1'b1;
                tick(HALF / 2);
            end else begin
                tick(HALF);
            end
        end
        dev_data = 1'b1;
    endtask

    // Wait (bounded) for a done/err pulse after d0/e0 snapshots, then let things settle.
    task automatic wait_result(input int d0, input int e0);
        bit seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (n_done != d0 || n_err != e0) begin
                seen = 1'b1;
                break;
            end
            tick(1);
        end
        chk("result_seen", 32'(seen), 32'd1);
        tick(20);
    endtask

    // Full frame with ACK: check every bit seen by the device and a single tx_done.
    task automatic run_frame(input string name, input logic [7:0] d, input logic [9:0] exp,
                             input int glitch_k);
        logic [9:0] bits;
        int d0, e0;
        d0 = n_done;
        e0 = n_err;
        send(d);
        chk({name, "_busy"}, 32'(tx_busy), 32'd1);
        dev_frame(11, 1'b1, glitch_k, bits);
        for (int k = 0; k < 10; k++)
            chk($sformatf("%s_b%0d", name, k), 32'(bits[k]), 32'(exp[k]));
        wait_result(d0, e0);
        chk({name, "_done"}, 32'(n_done - d0), 32'd1);
        chk({name, "_err"}, 32'(n_err - e0), 32'd0);
        chk({name, "_idle"}, {29'd0, tx_busy, ps2_clk_oe, ps2_data_oe}, 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] bits;
        int d0, e0, c_inh, c_st, t, t_err;
        bit ok;

        // Reset state
        tick(3);
        chk("rst_outs", {27'd0, tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe}, 32'd0);
        rst = 1'b0;
        tick(5);

        // Test 1/2: data patterns and parity
        run_frame("ed", 8'hED, 10'b1_1_11101101, 0);
        run_frame("x01", 8'h01, 10'b1_0_00000001, 0);
        run_frame("x00", 8'h00, 10'b1_1_00000000, 0);

        // Test 3: device never clocks
        d0 = n_done;
        e0 = n_err;
        send(8'h55);
        c_inh = 0;
        c_st  = 0;
        for (int i = 0; i < 1000; i++) begin
            if (ps2_clk_oe && !ps2_data_oe) c_inh++;
            else if (ps2_clk_oe && ps2_data_oe) c_st++;
            else break;
            tick(1);
        end
        chk("inhib_len", 32'(c_inh), 32'(INHIB_CYC));
        chk("start_len", 32'(c_st), 32'd1);
        t = 0;
        while (!tx_err && t < START_CYC + 100) begin
            tick(1);
            t++;
        end
        ok = (t >= START_CYC - 1) && (t <= START_CYC + 1);
        if (!ok) $display("FAIL start_to_len: got %0d expected %0d", t, START_CYC);
        chk("start_to", 32'(ok), 32'd1);
        chk("start_to_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 32'd0);
        chk("err_busy", 32'(tx_busy), 32'd1);
        tick(1);
        chk("err_busy_drop", 32'(tx_busy), 32'd0);
        tick(5);
        chk("start_to_cnt", 32'(n_err - e0), 32'd1);
        chk("start_to_nodone", 32'(n_done - d0), 32'd0);

        // Test 4: no ACK, then a clean frame
        d0 = n_done;
        e0 = n_err;
        send(8'hF3);
        dev_frame(11, 1'b0, 0, bits);
        for (int k = 0; k < 10; k++)
            chk($sformatf("f3_b%0d", k), 32'(bits[k]), 32'(k < 8 ? (8'hF3 >> k) & 1 : 1));
        wait_result(d0, e0);
        chk("noack_err", 32'(n_err - e0), 32'd1);
        chk("noack_done", 32'(n_done - d0), 32'd0);
        run_frame("x07", 8'h07, 10'b1_0_00000111, 0);

        // Test 5: device stops after 5 clocks; second request mid-frame is ignored
        d0 = n_done;
        e0 = n_err;
        send(8'h33);
        dev_frame(5, 1'b1, 0, bits);
        chk("stall_busy", 32'(tx_busy), 32'd1);
        send(8'hFF);
        t_err = -1;
        for (int i = 0; i < FRAME_CYC + 200; i++) begin
            if (tx_err) begin
                t_err = cyc;
                break;
            end
            tick(1);
        end
        t = t_err - t_fall1;
        ok = (t_err >= 0) && (t >= FRAME_CYC + int'(FILT)) && (t <= FRAME_CYC + int'(FILT) + 6);
        if (!ok) $display("FAIL frame_to_len: got %0d expected %0d", t, FRAME_CYC + int'(FILT) + 3);
        chk("frame_to", 32'(ok), 32'd1);
        tick(50);
        chk("ignored_stb", {30'd0, tx_busy, ps2_clk_oe}, 32'd0);
        chk("stall_err", 32'(n_err - e0), 32'd1);
        chk("stall_done", 32'(n_done - d0), 32'd0);

        // Test 5b: short glitch on the clock line must not advance the bit counter
        run_frame("glitch", 8'hA5, 10'b1_1_10100101, 3);

        // Test 6: reset in the middle of the data bits
        send(8'h3C);
        dev_frame(4, 1'b1, 0, bits);
        chk("pre_rst_busy", 32'(tx_busy), 32'd1);
        d0 = n_done;
        e0 = n_err;
        rst = 1'b1;
        tick(1);
        chk("rst_mid", {27'd0, tx_busy, tx_done, tx_err, ps2_clk_oe, ps2_data_oe}, 32'd0);
        rst = 1'b0;
        tick(20);
        chk("rst_pulses", 32'((n_done - d0) + (n_err - e0)), 32'd0);
        run_frame("x5a", 8'h5A, 10'b1_1_01011010, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
